// File: rtl/sram_controller_pkg.sv
// Shared types and helpers for the SRAM bus target: FSM state encoding and
// the bad-access decode used when a request is first sampled.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Range check works on the offset from the base, so an address just above the
    // top is rejected instead of wrapping onto word 0.
    function automatic logic access_is_bad(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] bytes,
        input logic        instr,
        input logic [3:0]  strobe
    );
        logic [31:0] offset;
        offset = addr - base;
        return (addr < base) || (offset >= bytes) || (addr[1:0] != 2'b00) ||
               (instr && (strobe != 4'b0000));
    endfunction

endpackage

// File: rtl/sram_latency_counter.sv
// Down-counter that times the SRAM read latency; load, decrement and a zero
// flag are exposed so the wait logic can be exercised on its own.
module sram_latency_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_controller.sv
// Bus target for the core's external memory port: decodes the request, drives a
// single-port synchronous SRAM and returns a registered ready/data/error response.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter int unsigned RAM_BYTES    = 65536,
    parameter int unsigned SRAM_LATENCY = 1,
    localparam int unsigned AW          = $clog2(RAM_BYTES) - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ext_valid,
    input  logic          ext_instruction,
    output logic          ext_ready,
    input  logic [31:0]   ext_address,
    input  logic [31:0]   ext_write_data,
    input  logic [3:0]    ext_write_strobe,
    output logic [31:0]   ext_read_data,
    output logic          bus_error,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    localparam int unsigned CW = $clog2(SRAM_LATENCY + 1);

    state_t          state_q, state_d;
    logic            req_bad;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic            accept, rd_done;

    logic            ext_ready_q, ext_ready_d;
    logic            bus_error_q, bus_error_d;
    logic [31:0]     ext_read_data_q, ext_read_data_d;
    logic            sram_en_q, sram_en_d;
    logic [3:0]      sram_we_q, sram_we_d;
    logic [AW-1:0]   sram_addr_q, sram_addr_d;
    logic [31:0]     sram_wdata_q, sram_wdata_d;

    assign req_bad = access_is_bad(ext_address, RAM_BASE, 32'(RAM_BYTES),
                                   ext_instruction, ext_write_strobe);

    sram_latency_counter #(
        .WIDTH (CW)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (CW'(SRAM_LATENCY - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACCESS decides read vs write from the registered strobe it is driving.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ext_valid) begin
                    state_d = req_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (sram_we_q != 4'b0000) begin
                    state_d = ST_RESP;
                end else begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        accept          = (state_q == ST_IDLE) && (state_d == ST_ACCESS);
        rd_done         = (state_q == ST_WAIT) && (state_d == ST_RESP);
        ext_ready_d     = (state_d == ST_RESP);
        bus_error_d     = (state_q == ST_IDLE) && (state_d == ST_RESP);
        ext_read_data_d = rd_done ? sram_rdata : 32'h0;
        sram_en_d       = accept;
        sram_we_d       = accept ? ext_write_strobe : 4'b0000;
        sram_addr_d     = accept ? AW'((ext_address - RAM_BASE) >> 2) : sram_addr_q;
        sram_wdata_d    = accept ? ext_write_data : sram_wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_ready_q     <= 1'b0;
            bus_error_q     <= 1'b0;
            ext_read_data_q <= '0;
            sram_en_q       <= 1'b0;
            sram_we_q       <= '0;
            sram_addr_q     <= '0;
            sram_wdata_q    <= '0;
        end else begin
            ext_ready_q     <= ext_ready_d;
            bus_error_q     <= bus_error_d;
            ext_read_data_q <= ext_read_data_d;
            sram_en_q       <= sram_en_d;
            sram_we_q       <= sram_we_d;
            sram_addr_q     <= sram_addr_d;
            sram_wdata_q    <= sram_wdata_d;
        end
    end

    assign ext_ready     = ext_ready_q;
    assign bus_error     = bus_error_q;
    assign ext_read_data = ext_read_data_q;
    assign sram_en       = sram_en_q;
    assign sram_we       = sram_we_q;
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;

endmodule
